// File: rtl/arbiter_request_agent_if.sv
// Handshake bundle between a request agent and its matrix arbiter.
// The master side drives pushes and arbiter grants; the slave side is the agent.
interface arbiter_request_agent_if #(
    parameter int unsigned NUM_REQUESTORS = 4,
    parameter int unsigned COUNT_WIDTH    = 4,
    parameter int unsigned STARVE_WIDTH   = 8
);
    logic [NUM_REQUESTORS-1:0]             push;
    logic [NUM_REQUESTORS-1:0]             grant;
    logic                                  grant_valid;
    logic [STARVE_WIDTH-1:0]               starve_limit;
    logic                                  clear_errors;
    logic [NUM_REQUESTORS-1:0]             req;
    logic [NUM_REQUESTORS*COUNT_WIDTH-1:0] pending_count;
    logic [NUM_REQUESTORS-1:0]             done;
    logic [NUM_REQUESTORS-1:0]             starved;
    logic [NUM_REQUESTORS-1:0]             overflow;
    logic                                  spurious_grant;

    modport master (
        output push, grant, grant_valid, starve_limit, clear_errors,
        input  req, pending_count, done, starved, overflow, spurious_grant
    );

    modport slave (
        input  push, grant, grant_valid, starve_limit, clear_errors,
        output req, pending_count, done, starved, overflow, spurious_grant
    );
endinterface

// File: rtl/arbiter_request_agent.sv
// Per-channel pending-transaction tracker feeding a matrix arbiter, with drain
// pulses, starvation detection and sticky overflow / grant-protocol error flags.
module arbiter_request_agent #(
    parameter int unsigned NUM_REQUESTORS = 4,
    parameter int unsigned COUNT_WIDTH    = 4,
    parameter int unsigned STARVE_WIDTH   = 8
) (
    input logic                    clk,
    input logic                    rst,
    arbiter_request_agent_if.slave bus
);

    localparam logic [COUNT_WIDTH-1:0]  CountMax = '1;
    localparam logic [COUNT_WIDTH-1:0]  CountOne = COUNT_WIDTH'(1);
    localparam logic [STARVE_WIDTH-1:0] WaitMax  = '1;

    logic [COUNT_WIDTH-1:0]    count_q [NUM_REQUESTORS];
    logic [COUNT_WIDTH-1:0]    count_d [NUM_REQUESTORS];
    logic [STARVE_WIDTH-1:0]   wait_q  [NUM_REQUESTORS];
    logic [STARVE_WIDTH-1:0]   wait_d  [NUM_REQUESTORS];
    logic [NUM_REQUESTORS-1:0] done_q, done_d;
    logic [NUM_REQUESTORS-1:0] overflow_q, overflow_d;
    logic                      spurious_q, spurious_d;

    logic [NUM_REQUESTORS-1:0] consume;
    logic [NUM_REQUESTORS-1:0] nonzero;
    logic [NUM_REQUESTORS-1:0] req;
    logic                      orphan_grant;
    logic                      multi_grant;
    logic                      valid_mismatch;

    // Request masks the last in-flight grant so the arbiter never over-grants.
    always_comb begin
        nonzero = '0;
        consume = '0;
        req     = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            nonzero[i] = (count_q[i] != '0);
            consume[i] = bus.grant[i] && nonzero[i];
            req[i]     = (count_q[i] > CountOne) ||
                         ((count_q[i] == CountOne) && !bus.grant[i]);
        end
    end

    always_comb begin
        overflow_d = bus.clear_errors ? '0 : overflow_q;
        done_d     = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            count_d[i] = count_q[i];
            if (bus.push[i] && !consume[i]) begin
                if (count_q[i] == CountMax) begin
                    overflow_d[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + CountOne;
                end
            end else if (!bus.push[i] && consume[i]) begin
                count_d[i] = count_q[i] - CountOne;
            end
            done_d[i] = (count_q[i] == CountOne) && (count_d[i] == '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            wait_d[i] = wait_q[i];
            if (!nonzero[i] || bus.grant[i]) begin
                wait_d[i] = '0;
            end else if (req[i] && (wait_q[i] != WaitMax)) begin
                wait_d[i] = wait_q[i] + STARVE_WIDTH'(1);
            end
        end
    end

    always_comb begin
        orphan_grant   = |(bus.grant & ~nonzero);
        multi_grant    = (bus.grant & (bus.grant - NUM_REQUESTORS'(1))) != '0;
        valid_mismatch = bus.grant_valid != (|bus.grant);
        // A fresh violation wins over a same-cycle clear.
        if (orphan_grant || multi_grant || valid_mismatch) begin
            spurious_d = 1'b1;
        end else if (bus.clear_errors) begin
            spurious_d = 1'b0;
        end else begin
            spurious_d = spurious_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                count_q[i] <= '0;
                wait_q[i]  <= '0;
            end
            done_q     <= '0;
            overflow_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                count_q[i] <= count_d[i];
                wait_q[i]  <= wait_d[i];
            end
            done_q     <= done_d;
            overflow_q <= overflow_d;
            spurious_q <= spurious_d;
        end
    end

    always_comb begin
        bus.pending_count = '0;
        bus.starved       = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            bus.pending_count[i*COUNT_WIDTH +: COUNT_WIDTH] = count_q[i];
            bus.starved[i] = (bus.starve_limit != '0) && (wait_q[i] >= bus.starve_limit);
        end
    end

    assign bus.req            = req;
    assign bus.done           = done_q;
    assign bus.overflow       = overflow_q;
    assign bus.spurious_grant = spurious_q;

endmodule

// File: tb/tb_arbiter_request_agent.sv
// Directed scoreboard bench: stimulus queues expected outputs per cycle, a
// negedge monitor pops and compares them against the agent's outputs.
module tb_arbiter_request_agent;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic [3:0]  req;
        logic [3:0]  done;
        logic [3:0]  starved;
        logic [3:0]  overflow;
        logic        spur;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    arbiter_request_agent_if #(
        .NUM_REQUESTORS(4),
        .COUNT_WIDTH   (4),
        .STARVE_WIDTH  (8)
    ) bus ();

    arbiter_request_agent #(
        .NUM_REQUESTORS(4),
        .COUNT_WIDTH   (4),
        .STARVE_WIDTH  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: stale expectation for cycle %0d checked at %0d",
                         e.name, e.cyc, cyc);
            end else if (bus.req !== e.req || bus.done !== e.done ||
                         bus.starved !== e.starved || bus.overflow !== e.overflow ||
                         bus.spurious_grant !== e.spur || bus.pending_count !== e.cnt) begin
                failures++;
                $display({"FAIL %s: got req=%b done=%b starved=%b ovf=%b spur=%b cnt=%h ",
                          "required req=%b done=%b starved=%b ovf=%b spur=%b cnt=%h"},
                         e.name, bus.req, bus.done, bus.starved, bus.overflow,
                         bus.spurious_grant, bus.pending_count, e.req, e.done, e.starved,
                         e.overflow, e.spur, e.cnt);
            end
        end
    end

    task automatic drive(input logic [3:0] p, input logic [3:0] g, input logic gv,
                         input logic clr);
        @(posedge clk);
        #1;
        bus.push         = p;
        bus.grant        = g;
        bus.grant_valid  = gv;
        bus.clear_errors = clr;
    endtask

    task automatic expect_out(input string name, input logic [3:0] r, input logic [3:0] d,
                              input logic [3:0] s, input logic [3:0] o, input logic sp,
                              input logic [15:0] c);
        exp_t e;
        e.name = name; e.cyc = cyc; e.req = r; e.done = d; e.starved = s;
        e.overflow = o; e.spur = sp; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("reset_state", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        bus.push = '0; bus.grant = '0; bus.grant_valid = 1'b0;
        bus.clear_errors = 1'b0; bus.starve_limit = '0;

        // Single push, granted the next cycle.
        reset_dut();
        drive(4'b0001, 4'b0, 1'b0, 1'b0);
        expect_out("s1_idle", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s1_req", 4'b0001, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0001);
        drive(4'b0, 4'b0001, 1'b1, 1'b0);
        expect_out("s1_grant", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0001);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s1_done", 4'b0, 4'b0001, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s1_after", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);

        // Three pushes on ch1, grant held for three consumes.
        reset_dut();
        drive(4'b0010, 4'b0, 1'b0, 1'b0);
        drive(4'b0010, 4'b0, 1'b0, 1'b0);
        expect_out("s2_c1", 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0010);
        drive(4'b0010, 4'b0, 1'b0, 1'b0);
        expect_out("s2_c2", 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0020);
        drive(4'b0, 4'b0010, 1'b1, 1'b0);
        expect_out("s2_g3", 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0030);
        drive(4'b0, 4'b0010, 1'b1, 1'b0);
        expect_out("s2_g2", 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0020);
        drive(4'b0, 4'b0010, 1'b1, 1'b0);
        expect_out("s2_g1_mask", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0010);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s2_done", 4'b0, 4'b0010, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s2_after", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);

        // Sixteen pushes on ch2 saturate the counter and set overflow.
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            drive(4'b0100, 4'b0, 1'b0, 1'b0);
            if (k == 15) expect_out("s3_c15", 4'b0100, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0F00);
        end
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s3_ovf", 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b0, 16'h0F00);
        drive(4'b0100, 4'b0100, 1'b1, 1'b0);
        expect_out("s3_pg_max", 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b0, 16'h0F00);
        drive(4'b0, 4'b0, 1'b0, 1'b1);
        expect_out("s3_clr", 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b0, 16'h0F00);
        drive(4'b0100, 4'b0100, 1'b1, 1'b0);
        expect_out("s3_cleared", 4'b0100, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0F00);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s3_no_new_ovf", 4'b0100, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0F00);
        drive(4'b0100, 4'b0, 1'b0, 1'b1);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s3_err_beats_clr", 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b0, 16'h0F00);

        // Starvation on ch3 with a limit of 5 wait cycles.
        bus.starve_limit = 8'd5;
        reset_dut();
        drive(4'b1000, 4'b0, 1'b0, 1'b0);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s4_req", 4'b1000, 4'b0, 4'b0, 4'b0, 1'b0, 16'h1000);
        for (int k = 0; k < 4; k++) drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s4_wait4", 4'b1000, 4'b0, 4'b0, 4'b0, 1'b0, 16'h1000);
        drive(4'b0, 4'b1000, 1'b1, 1'b0);
        expect_out("s4_starved", 4'b0, 4'b0, 4'b1000, 4'b0, 1'b0, 16'h1000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s4_released", 4'b0, 4'b1000, 4'b0, 4'b0, 1'b0, 16'h0000);
        bus.starve_limit = '0;

        // Grant protocol violations and their clearing.
        reset_dut();
        drive(4'b0, 4'b0001, 1'b1, 1'b0);
        expect_out("s5_orphan_cyc", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s5_orphan_set", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b1);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s5_orphan_clr", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0011, 4'b0, 1'b0, 1'b0);
        drive(4'b0, 4'b0011, 1'b1, 1'b0);
        expect_out("s5_multi_cyc", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0011);
        drive(4'b0, 4'b0, 1'b1, 1'b1);
        expect_out("s5_multi_set", 4'b0, 4'b0011, 4'b0, 4'b0, 1'b1, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b1);
        expect_out("s5_err_beats_clr", 4'b0, 4'b0, 4'b0, 4'b0, 1'b1, 16'h0000);
        drive(4'b0001, 4'b0, 1'b0, 1'b0);
        expect_out("s5_clr2", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0001, 1'b0, 1'b0);
        expect_out("s5_gv_low_cyc", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0001);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s5_gv_low_set", 4'b0, 4'b0001, 4'b0, 4'b0, 1'b1, 16'h0000);

        // Asynchronous reset mid-transaction, then all channels pushed together.
        reset_dut();
        drive(4'b0010, 4'b0, 1'b0, 1'b0);
        drive(4'b0010, 4'b0, 1'b0, 1'b0);
        expect_out("s6_c1", 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0010);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s6_c2", 4'b0010, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0020);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        expect_out("s6_async_rst", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0010, 4'b0, 1'b0, 1'b0);
        expect_out("s6_push_in_rst", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        rst = 1'b1;
        expect_out("s6_release", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b1111, 4'b0, 1'b0, 1'b0);
        expect_out("s6_no_done", 4'b0, 4'b0, 4'b0, 4'b0, 1'b0, 16'h0000);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        expect_out("s6_all_push", 4'b1111, 4'b0, 4'b0, 4'b0, 1'b0, 16'h1111);

        drive(4'b0, 4'b0, 1'b0, 1'b0);
        drive(4'b0, 4'b0, 1'b0, 1'b0);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter_request_agent.md
ARBITER_REQUEST_AGENT -- requirements
Module: arbiter_request_agent

Interface
REQ-001 SHALL have parameter NUM_REQUESTORS, default 4, number of request channels.
REQ-002 SHALL have parameter COUNT_WIDTH, default 4, width of each per-channel pending-transaction counter.
REQ-003 SHALL have parameter STARVE_WIDTH, default 8, width of each per-channel wait counter and of starve_limit.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port push  input  NUM_REQUESTORS  per-channel one-cycle pulse enqueueing one transaction.
REQ-007 SHALL have port grant  input  NUM_REQUESTORS  grant vector from matrix arbiter, registered one cycle after req.
REQ-008 SHALL have port grant_valid  input  1  arbiter OR-of-grant indication.
REQ-009 SHALL have port starve_limit  input  STARVE_WIDTH  wait-cycle threshold; 0 disables starvation detection.
REQ-010 SHALL have port clear_errors  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port req  output  NUM_REQUESTORS  request vector to arbiter.
REQ-012 SHALL have port pending_count  output  NUM_REQUESTORS*COUNT_WIDTH  per-channel counters, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH].
REQ-013 SHALL have port done  output  NUM_REQUESTORS  registered one-cycle pulse when channel drains to zero.
REQ-014 SHALL have port starved  output  NUM_REQUESTORS  per-channel starvation level flag.
REQ-015 SHALL have port overflow  output  NUM_REQUESTORS  per-channel sticky dropped-push flag.
REQ-016 SHALL have port spurious_grant  output  1  sticky protocol-violation flag.

Function
REQ-017 SHALL define consume_i = grant[i] AND (count_i != 0).
REQ-018 SHALL update count_i each cycle: +1 on push[i], -1 on consume_i, unchanged when both or neither.
REQ-019 SHALL, on push[i] with count_i at max (all ones) and no consume_i, drop the push, hold count_i, set overflow[i].
REQ-020 SHALL accept push[i] at max when consume_i is in the same cycle (net unchanged, no overflow).
REQ-021 SHALL drive req[i] combinationally as (count_i > 1) OR (count_i == 1 AND NOT grant[i]), masking the final in-flight grant so the arbiter never grants beyond pending work.
REQ-022 SHALL pulse done[i] high for exactly one cycle, the cycle after count_i goes 1 -> 0.
REQ-023 SHALL keep per-channel wait_i: increment (saturating at all ones) when req[i]=1 and grant[i]=0; clear to 0 on grant[i]=1 or count_i=0.
REQ-024 SHALL assert starved[i] when starve_limit != 0 and wait_i >= starve_limit; deassert as soon as wait_i clears.
REQ-025 SHALL set spurious_grant when any of: grant[i]=1 with count_i=0; more than one grant bit set; grant_valid != OR of grant.
REQ-026 SHALL clear overflow and spurious_grant on clear_errors; a same-cycle new error takes priority and sets the flag.
REQ-027 SHALL treat each channel independently; simultaneous pushes on all channels are all accepted.

Reset
REQ-028 SHALL, while rst=0, force all counters, wait counters, done, starved, overflow, spurious_grant and req to 0 immediately, independent of clk.
REQ-029 SHALL resume normal operation on the first rising edge after rst returns high; pushes during reset are lost.
REQ-030 SHALL, on reset mid-transaction, discard pending counts with no done pulse.

Verification
REQ-031 SHALL cover: push[0] once, arbiter grants next cycle -> req[0] high 1 cycle, count0 1->0, done[0] pulse 1 cycle later, no spurious_grant.
REQ-032 SHALL cover: 3 pushes on ch1, grant[1] held continuously -> count1 3,2,1,0, req[1] low while count1=1 and grant[1]=1, exactly 3 consumes.
REQ-033 SHALL cover: COUNT_WIDTH=4, 16 pushes on ch2 with no grant -> count2=15, overflow[2]=1; push plus grant at 15 -> count stays 15, no new overflow.
REQ-034 SHALL cover: starve_limit=5, ch3 requesting, grant withheld -> starved[3] high after 5 wait cycles, low the cycle after grant[3].
REQ-035 SHALL cover: grant=4'b0011 or grant[0] with count0=0 or grant_valid=0 with grant!=0 -> spurious_grant=1, cleared by clear_errors.
REQ-036 SHALL cover: rst asserted between edges with count1=2 -> all outputs 0 immediately, no done pulse after release.
